// File: rtl/ifetch_pkg.sv
// ifetch shared definitions: FSM state encoding and default widths.
// Used by the ifetch core; IFETCH_PREFETCH_EN enables the PREF state.
package ifetch_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_OPCODE_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PREF = 2'd2
  } state_e;

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory read bus between ifetch (master) and memory.
// Read data is qualified by mem_ready.
interface ifetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;

  modport master (
    output mem_addr,
    output mem_read,
    input  mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    output mem_data,
    output mem_ready
  );

endinterface

// File: rtl/ifetch_reg.sv
// Enable-gated register with asynchronous active-low reset value.
// Shared building block for pc, ir, flags and prefetch buffer.
module ifetch_reg #(
  parameter int           W   = 16,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: pc, instruction register and status flags.
// Define IFETCH_PREFETCH_EN to add a one-word prefetch buffer.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int INITIAL_PC   = 0
) (
  input  logic                           clock,
  input  logic                           notReset,
  input  logic                           fetch,
  input  logic                           pc_load,
  input  logic [ADDR_WIDTH-1:0]          pc_in,
  input  logic                           flags_load,
  input  logic                           alu_carry,
  input  logic                           alu_zero,
  ifetch_if.master                       mem,
  output logic [OPCODE_WIDTH-1:0]        opcode,
  output logic                           carry,
  output logic                           zero,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic                           busy
);

  localparam logic [ADDR_WIDTH-1:0] PC_RST =
    ADDR_WIDTH'(INITIAL_PC);

`ifdef IFETCH_PREFETCH_EN
  localparam state_e LOAD_NEXT = PREF;
`else
  localparam state_e LOAD_NEXT = IDLE;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                  pc_en;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  ir_en;

`ifdef IFETCH_PREFETCH_EN
  logic [DATA_WIDTH-1:0] pbuf_q, pbuf_d;
  logic                  pbuf_en;
  logic                  pval_q, pval_d;
`endif

  assign pc_inc = pc_q + 1'b1;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_en   = 1'b0;
    ir_d    = mem.mem_data;
    ir_en   = 1'b0;
`ifdef IFETCH_PREFETCH_EN
    pbuf_d  = mem.mem_data;
    pbuf_en = 1'b0;
    pval_d  = pc_load ? 1'b0 : pval_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_d  = pc_in;
          pc_en = 1'b1;
        end
`ifdef IFETCH_PREFETCH_EN
        if (fetch && pval_q && !pc_load) begin
          ir_d    = pbuf_q;
          ir_en   = 1'b1;
          pc_d    = pc_inc;
          pc_en   = 1'b1;
          pval_d  = 1'b0;
          state_d = PREF;
        end else if (fetch) begin
          state_d = REQ;
        end
`else
        if (fetch) state_d = REQ;
`endif
      end
      REQ: begin
        // an abort wins over completion in the same cycle
        if (pc_load) begin
          pc_d    = pc_in;
          pc_en   = 1'b1;
          state_d = IDLE;
        end else if (mem.mem_ready) begin
          ir_en   = 1'b1;
          pc_d    = pc_inc;
          pc_en   = 1'b1;
          state_d = LOAD_NEXT;
        end
      end
`ifdef IFETCH_PREFETCH_EN
      PREF: begin
        if (pc_load) begin
          pc_d    = pc_in;
          pc_en   = 1'b1;
          state_d = fetch ? REQ : IDLE;
        end else if (fetch && mem.mem_ready) begin
          ir_en   = 1'b1;
          pc_d    = pc_inc;
          pc_en   = 1'b1;
          state_d = PREF;
        end else if (fetch) begin
          state_d = REQ;
        end else if (mem.mem_ready) begin
          pbuf_en = 1'b1;
          pval_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  ifetch_reg #(.W(ADDR_WIDTH), .RST(PC_RST)) u_pc (
    .clk(clock), .rst_n(notReset), .en(pc_en),
    .d(pc_d), .q(pc_q)
  );

  ifetch_reg #(.W(DATA_WIDTH)) u_ir (
    .clk(clock), .rst_n(notReset), .en(ir_en),
    .d(ir_d), .q(ir_q)
  );

  ifetch_reg #(.W(2)) u_flags (
    .clk(clock), .rst_n(notReset), .en(flags_load),
    .d({alu_carry, alu_zero}), .q({carry, zero})
  );

`ifdef IFETCH_PREFETCH_EN
  ifetch_reg #(.W(DATA_WIDTH)) u_pbuf (
    .clk(clock), .rst_n(notReset), .en(pbuf_en),
    .d(pbuf_d), .q(pbuf_q)
  );

  ifetch_reg #(.W(1)) u_pval (
    .clk(clock), .rst_n(notReset), .en(1'b1),
    .d(pval_d), .q(pval_q)
  );
`endif

  assign mem.mem_addr = pc_q;
  assign mem.mem_read = (state_q == REQ) || (state_q == PREF);
  assign busy         = (state_q == REQ);
  assign opcode       = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand      = ir_q[DATA_WIDTH-OPCODE_WIDTH-1:0];

endmodule
